// File: rtl/pattern_checker_if.sv
// Bus bundle between the read-back stream source and the pattern checker.
// The master side supplies run control and read-back words; the slave side
// (the checker) returns run status, error capture and the expected word.
interface pattern_checker_if;
    logic        start;
    logic        abort;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  err_count;
    logic        first_err_valid;
    logic [5:0]  first_err_index;
    logic [15:0] first_err_expected;
    logic [15:0] first_err_actual;
    logic [15:0] expected;

    modport master (
        output start, abort, rd_valid, rd_data,
        input  busy, done, pass, err_count, first_err_valid,
        input  first_err_index, first_err_expected, first_err_actual, expected
    );

    modport slave (
        input  start, abort, rd_valid, rd_data,
        output busy, done, pass, err_count, first_err_valid,
        output first_err_index, first_err_expected, first_err_actual, expected
    );
endinterface

// File: rtl/pattern_checker.sv
// Read-back checker for the memory test path. Regenerates the 64-entry
// walking-bit sequence, compares every accepted read-back word against it,
// counts mismatches (saturating), captures the first failing word and
// reports pass/fail after PASSES complete sweeps.
module pattern_checker #(
    parameter int PASSES = 1
) (
    input  logic            clk,
    input  logic            reset,
    pattern_checker_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [3:0] LAST_SWEEP = 4'(PASSES - 1);

    // Walking-bit word for a 6-bit index: the upper two bits select the
    // group (rolling one/zero, right/left), the lower four the position.
    function automatic logic [15:0] pattern_word(input logic [5:0] idx);
        logic [15:0] w;
        case (idx[5:4])
            2'd0:    w = 16'h8000 >> idx[3:0];
            2'd1:    w = ~(16'h8000 >> idx[3:0]);
            2'd2:    w = 16'h0001 << idx[3:0];
            2'd3:    w = ~(16'h0001 << idx[3:0]);
            default: w = 16'h8000;
        endcase
        return w;
    endfunction

    state_t      state_r, state_s;
    logic [5:0]  index_r, index_s;
    logic [3:0]  sweep_r, sweep_s;
    logic [7:0]  err_count_r, err_count_s;
    logic        fe_valid_r, fe_valid_s;
    logic [5:0]  fe_index_r, fe_index_s;
    logic [15:0] fe_expected_r, fe_expected_s;
    logic [15:0] fe_actual_r, fe_actual_s;
    logic        pass_r, pass_s;
    logic [15:0] expected_s;
    logic        mismatch_s;

    assign expected_s = pattern_word(index_r);

    // Next-state, counter and capture logic for the run FSM.
    always_comb begin
        state_s       = state_r;
        index_s       = index_r;
        sweep_s       = sweep_r;
        err_count_s   = err_count_r;
        fe_valid_s    = fe_valid_r;
        fe_index_s    = fe_index_r;
        fe_expected_s = fe_expected_r;
        fe_actual_s   = fe_actual_r;
        pass_s        = pass_r;
        mismatch_s    = (bus.rd_data != expected_s);

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s       = ST_CHECK;
                    index_s       = 6'd0;
                    sweep_s       = 4'd0;
                    err_count_s   = 8'd0;
                    fe_valid_s    = 1'b0;
                    fe_index_s    = 6'd0;
                    fe_expected_s = 16'h0000;
                    fe_actual_s   = 16'h0000;
                    pass_s        = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (bus.abort) begin
                    // the word presented alongside abort is deliberately dropped
                    state_s = ST_IDLE;
                end else if (bus.rd_valid) begin
                    if (mismatch_s) begin
                        if (err_count_r != 8'hFF) begin
                            err_count_s = err_count_r + 8'd1;
                        end else begin
                            err_count_s = err_count_r;
                        end
                        if (!fe_valid_r) begin
                            fe_valid_s    = 1'b1;
                            fe_index_s    = index_r;
                            fe_expected_s = expected_s;
                            fe_actual_s   = bus.rd_data;
                        end else begin
                            fe_valid_s = fe_valid_r;
                        end
                    end else begin
                        err_count_s = err_count_r;
                    end
                    index_s = index_r + 6'd1;
                    if (index_r == 6'd63) begin
                        if (sweep_r == LAST_SWEEP) begin
                            // pass is settled on entry so it is valid with done
                            state_s = ST_FINISH;
                            pass_s  = (err_count_s == 8'd0);
                        end else begin
                            sweep_s = sweep_r + 4'd1;
                        end
                    end else begin
                        sweep_s = sweep_r;
                    end
                end else begin
                    state_s = ST_CHECK;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
                if (bus.abort) begin
                    pass_s = 1'b0;
                end else begin
                    pass_s = pass_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and result registers; asynchronous reset returns everything to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            index_r       <= 6'd0;
            sweep_r       <= 4'd0;
            err_count_r   <= 8'd0;
            fe_valid_r    <= 1'b0;
            fe_index_r    <= 6'd0;
            fe_expected_r <= 16'h0000;
            fe_actual_r   <= 16'h0000;
            pass_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            index_r       <= index_s;
            sweep_r       <= sweep_s;
            err_count_r   <= err_count_s;
            fe_valid_r    <= fe_valid_s;
            fe_index_r    <= fe_index_s;
            fe_expected_r <= fe_expected_s;
            fe_actual_r   <= fe_actual_s;
            pass_r        <= pass_s;
        end
    end

    assign bus.busy               = (state_r != ST_IDLE);
    assign bus.done               = (state_r == ST_FINISH);
    assign bus.pass               = pass_r;
    assign bus.err_count          = err_count_r;
    assign bus.first_err_valid    = fe_valid_r;
    assign bus.first_err_index    = fe_index_r;
    assign bus.first_err_expected = fe_expected_r;
    assign bus.first_err_actual   = fe_actual_r;
    assign bus.expected           = expected_s;

endmodule

// File: tb/tb_pattern_checker.sv
// Randomized scoreboard bench for pattern_checker (PASSES = 4).
module tb_pattern_checker;

    localparam int NP     = 4;
    localparam int NWORDS = 64 * NP;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    pattern_checker_if bus ();

    pattern_checker #(.PASSES(NP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          done_cyc;
        logic [7:0]  errs;
        logic        pass;
        logic        fev;
        logic [5:0]  fei;
        logic [15:0] fee;
        logic [15:0] fea;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [15:0] stim[NWORDS];
    int          gap[NWORDS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference word: single set bit at a position walking right (groups 0,1)
    // or left (groups 2,3); odd groups are the inverted form.
    function automatic logic [15:0] ref_word(input int i);
        int          g;
        int          n;
        int          pos;
        logic [15:0] w;
        g   = (i % 64) / 16;
        n   = i % 16;
        pos = (g < 2) ? (15 - n) : n;
        w   = 16'h0000;
        w[pos] = 1'b1;
        if (g % 2 == 1) w = ~w;
        return w;
    endfunction

    // Result of checking the first n stimulus words of a run.
    task automatic compute_expect(input int n, output exp_t e);
        int cnt;
        cnt   = 0;
        e.fev = 1'b0;
        e.fei = 6'd0;
        e.fee = 16'h0000;
        e.fea = 16'h0000;
        for (int i = 0; i < n; i++) begin
            if (stim[i] != ref_word(i)) begin
                cnt++;
                if (!e.fev) begin
                    e.fev = 1'b1;
                    e.fei = 6'(i % 64);
                    e.fee = ref_word(i);
                    e.fea = stim[i];
                end
            end
        end
        e.errs     = (cnt > 255) ? 8'd255 : 8'(cnt);
        e.pass     = (cnt == 0);
        e.done_cyc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_clean();
        for (int i = 0; i < NWORDS; i++) begin
            stim[i] = ref_word(i);
            gap[i]  = 0;
        end
    endtask

    task automatic fill_gaps();
        for (int i = 0; i < NWORDS; i++) begin
            gap[i] = ($urandom_range(99) < 20) ? int'($urandom_range(3, 1)) : 0;
        end
    endtask

    task automatic start_run(output int k);
        bus.start = 1'b1;
        step();
        k = cyc;
        bus.start = 1'b0;
        check("busy_rise", bus.busy, 1);
        check("pass_cleared", bus.pass, 0);
        check("err_cleared", bus.err_count, 0);
        check("fev_cleared", bus.first_err_valid, 0);
    endtask

    // Full run: expected outcome queued up front, monitor checks at done.
    task automatic run_full(input int glitch_at);
        int   k;
        int   stalls;
        exp_t e;
        start_run(k);
        compute_expect(NWORDS, e);
        stalls = 0;
        for (int i = 0; i < NWORDS; i++) stalls += gap[i];
        e.done_cyc = k + NWORDS + stalls;
        sb_q.push_back(e);
        for (int i = 0; i < NWORDS; i++) begin
            for (int s = 0; s < gap[i]; s++) begin
                bus.rd_valid = 1'b0;
                bus.rd_data  = 16'($urandom);
                step();
            end
            check("expected_word", bus.expected, ref_word(i));
            bus.rd_valid = 1'b1;
            bus.rd_data  = stim[i];
            if (i == glitch_at) bus.start = 1'b1;
            step();
            bus.start = 1'b0;
        end
        bus.rd_valid = 1'b0;
        step();
        check("done_single", bus.done, 0);
        check("busy_after", bus.busy, 0);
        check("pass_held", bus.pass, e.pass);
    endtask

    // Monitor: every done pulse is matched against the oldest queued prediction.
    always @(posedge clk) begin
        #1;
        if (!reset && bus.done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_cycle", cyc, mon_e.done_cyc);
                check("err_count", bus.err_count, mon_e.errs);
                check("pass", bus.pass, mon_e.pass);
                check("first_err_valid", bus.first_err_valid, mon_e.fev);
                check("first_err_index", bus.first_err_index, mon_e.fei);
                check("first_err_expected", bus.first_err_expected, mon_e.fee);
                check("first_err_actual", bus.first_err_actual, mon_e.fea);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_pass"}, bus.pass, 0);
        check({tag, "_err"}, bus.err_count, 0);
        check({tag, "_fev"}, bus.first_err_valid, 0);
        check({tag, "_fei"}, bus.first_err_index, 0);
        check({tag, "_fee"}, bus.first_err_expected, 0);
        check({tag, "_fea"}, bus.first_err_actual, 0);
        check({tag, "_expected"}, bus.expected, 16'h8000);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        exp_t e;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd_data  = 16'h0000;
        step();
        step();
        check_reset_values("rst");
        reset = 1'b0;
        step();
        check_reset_values("idle");

        // clean sweep, no stalls
        fill_clean();
        run_full(-1);

        // single fault at index 0x13
        fill_clean();
        stim[8'h13] = 16'hEFFE;
        run_full(-1);

        // all-zero and constant 5A5A read-back: every word mismatches, saturates
        fill_clean();
        for (int i = 0; i < NWORDS; i++) stim[i] = 16'h0000;
        run_full(-1);
        fill_clean();
        for (int i = 0; i < NWORDS; i++) stim[i] = 16'h5A5A;
        run_full(-1);

        // random stalls with correct data
        fill_clean();
        fill_gaps();
        run_full(-1);

        // start pulsed mid-run must be ignored
        fill_clean();
        run_full(10);

        // abort after 20 words; the word presented with abort is not compared
        fill_clean();
        stim[5] = ~ref_word(5);
        start_run(k);
        for (int i = 0; i < 20; i++) begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = stim[i];
            step();
        end
        bus.rd_data  = ~ref_word(20);
        bus.abort    = 1'b1;
        step();
        bus.abort    = 1'b0;
        bus.rd_valid = 1'b0;
        compute_expect(20, e);
        check("abort_busy", bus.busy, 0);
        check("abort_err", bus.err_count, e.errs);
        check("abort_fev", bus.first_err_valid, e.fev);
        check("abort_fei", bus.first_err_index, e.fei);
        check("abort_fee", bus.first_err_expected, e.fee);
        check("abort_fea", bus.first_err_actual, e.fea);
        check("abort_pass", bus.pass, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_done", bus.done, 0);
        end
        fill_clean();
        run_full(-1);

        // reset mid-run at index 40
        fill_clean();
        stim[3] = 16'h1234;
        start_run(k);
        for (int i = 0; i < 40; i++) begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = stim[i];
            step();
        end
        bus.rd_valid = 1'b0;
        check("pre_reset_err", bus.err_count, 1);
        reset = 1'b1;
        step();
        check_reset_values("midrst");
        reset = 1'b0;
        step();
        check("post_reset_done", bus.done, 0);
        fill_clean();
        run_full(-1);

        // random faults and stalls
        for (int r = 0; r < 4; r++) begin
            fill_clean();
            fill_gaps();
            for (int i = 0; i < NWORDS; i++) begin
                if ($urandom_range(39) == 0) begin
                    stim[i][$urandom_range(15)] = ~stim[i][$urandom_range(15)];
                    stim[i] = stim[i] ^ 16'(16'h0001 << $urandom_range(15));
                end
            end
            run_full(-1);
        end

        step();
        step();
        check("pending_done", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
